fetch_queue: RTL and testbench

Instruction fetch queue between the program counter / instruction memory (IF) and the decode stage (ID). The IF side pushes fetched {pc, instruction} pairs. The ID side pops them in order. Its not-full indication is the enable for the program counter register, so a stalled decoder back-pressures fetch. A flush input discards all queued entries on a taken branch, jump or trap redirect.

---
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr} buffer between instruction fetch and decode.
// Not-full drives the PC enable; a flush discards every queued entry on a redirect.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_flush,
   input  logic                   i_wr_valid,
   input  logic [31:0]            i_wr_pc,
   input  logic [31:0]            i_wr_instr,
   output logic                   o_wr_ready,
   output logic                   o_rd_valid,
   output logic [31:0]            o_rd_pc,
   output logic [31:0]            o_rd_instr,
   input  logic                   i_rd_ready,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_fire_s;
   logic          rd_fire_s;

   // Handshakes depend only on the registered count, so i_rd_ready never reaches o_wr_ready.
   assign o_wr_ready = (count_q != FULL_CNT);
   assign o_rd_valid = (count_q != {(AW + 1){1'b0}});
   assign o_count    = count_q;
   assign wr_fire_s  = i_wr_valid && o_wr_ready && !i_flush;
   assign rd_fire_s  = o_rd_valid && i_rd_ready && !i_flush;

   // Head entry, or a NOP with PC 0 when empty so a consumer that ignores valid decodes a NOP.
   always_comb begin
      o_rd_pc    = 32'h0000_0000;
      o_rd_instr = NOP_INSTR;
      if (o_rd_valid) begin
         o_rd_pc    = mem_q[rd_ptr_q][63:32];
         o_rd_instr = mem_q[rd_ptr_q][31:0];
      end else begin
         o_rd_pc    = 32'h0000_0000;
         o_rd_instr = NOP_INSTR;
      end
   end

   // Next pointer and occupancy state; flush overrides any handshake in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {(AW + 1){1'b0}};
      end else begin
         if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW + 1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are never cleared because the count gates visibility.
   always_ff @(posedge i_clk) begin
      if (wr_fire_s) begin
         mem_q[wr_ptr_q] <= {i_wr_pc, i_wr_instr};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model acting as the scoreboard.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_wr_valid = 1'b0;
   logic [31:0] i_wr_pc = 32'h0;
   logic [31:0] i_wr_instr = 32'h0;
   logic        o_wr_ready;
   logic        o_rd_valid;
   logic [31:0] o_rd_pc;
   logic [31:0] o_rd_instr;
   logic        i_rd_ready = 1'b0;
   logic [$clog2(DEPTH):0] o_count;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_wr_valid(i_wr_valid), .i_wr_pc(i_wr_pc), .i_wr_instr(i_wr_instr),
      .o_wr_ready(o_wr_ready), .o_rd_valid(o_rd_valid), .o_rd_pc(o_rd_pc),
      .o_rd_instr(o_rd_instr), .i_rd_ready(i_rd_ready), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rr, input logic fl);
      i_wr_valid = wv;
      i_wr_pc    = pc;
      i_wr_instr = ins;
      i_rd_ready = rr;
      i_flush    = fl;
   endtask

   // Scoreboard/monitor: checks the presented outputs against the model, then applies
   // the handshake that the coming rising edge will perform.
   always @(negedge i_clk) begin
      if (i_reset) begin
         exp_q.delete();
         chk("rst_count", 64'(o_count), 64'd0);
         chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
         chk("rst_wr_ready", 64'(o_wr_ready), 64'd1);
         chk("rst_instr", 64'(o_rd_instr), 64'(NOP_INSTR));
      end else begin
         chk("count", 64'(o_count), 64'(exp_q.size()));
         chk("rd_valid", 64'(o_rd_valid), 64'(exp_q.size() != 0));
         chk("wr_ready", 64'(o_wr_ready), 64'(exp_q.size() != DEPTH));
         if (exp_q.size() != 0) begin
            chk("head", {o_rd_pc, o_rd_instr}, exp_q[0]);
         end else begin
            chk("empty_out", {o_rd_pc, o_rd_instr}, {32'h0, NOP_INSTR});
         end
         if (i_flush) begin
            exp_q.delete();
         end else begin
            automatic bit do_wr = i_wr_valid && (exp_q.size() != DEPTH);
            if (i_rd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (do_wr) exp_q.push_back({i_wr_pc, i_wr_instr});
         end
      end
   end

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      chk("idle_valid", 64'(o_rd_valid), 64'd0);
      chk("idle_ready", 64'(o_wr_ready), 64'd1);
      chk("idle_count", 64'(o_count), 64'd0);
      chk("idle_pc", 64'(o_rd_pc), 64'd0);
      chk("idle_instr", 64'(o_rd_instr), 64'(NOP_INSTR));
      i_reset = 1'b0;

      // Fill with reads stalled, then a fifth write that must be ignored.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
         step();
      end
      chk("full_count", 64'(o_count), 64'd4);
      chk("full_ready", 64'(o_wr_ready), 64'd0);
      drive(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
      step();
      chk("fifth_count", 64'(o_count), 64'd4);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(o_rd_pc), 64'(4 * i));
         chk("drain_instr", 64'(o_rd_instr), 64'(32'hA0 + 32'(i)));
         step();
      end
      chk("drained_valid", 64'(o_rd_valid), 64'd0);

      // Streaming: each pc appears at the head one cycle after it is written.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0);
         step();
         chk("stream_count", 64'(o_count), 64'd1);
         chk("stream_pc", 64'(o_rd_pc), 64'(32'h40 + 32'(4 * i)));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Full with simultaneous read and write: read pops, write dropped.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h10, 32'hC4, 1'b1, 1'b0);
      step();
      chk("fullrw_count", 64'(o_count), 64'd3);
      chk("fullrw_ready", 64'(o_wr_ready), 64'd1);
      chk("fullrw_head", 64'(o_rd_pc), 64'h4);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (3) step();
      chk("fullrw_empty", 64'(o_count), 64'd0);

      // Flush with three queued entries and a concurrent write.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h80 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h100, 32'hD9, 1'b1, 1'b1);
      step();
      chk("flush_count", 64'(o_count), 64'd0);
      chk("flush_valid", 64'(o_rd_valid), 64'd0);
      chk("flush_ready", 64'(o_wr_ready), 64'd1);
      drive(1'b1, 32'h200, 32'hDA, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("redir_count", 64'(o_count), 64'd1);
      chk("redir_pc", 64'(o_rd_pc), 64'h200);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Asynchronous reset between edges with two entries queued.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2 i_reset = 1'b1;
      #1;
      chk("arst_count", 64'(o_count), 64'd0);
      chk("arst_valid", 64'(o_rd_valid), 64'd0);
      chk("arst_ready", 64'(o_wr_ready), 64'd1);
      chk("arst_pc", 64'(o_rd_pc), 64'd0);
      chk("arst_instr", 64'(o_rd_instr), 64'(NOP_INSTR));
      @(negedge i_clk);
      #2 i_reset = 1'b0;
      step();
      chk("post_rst_count", 64'(o_count), 64'd0);
      chk("post_rst_valid", 64'(o_rd_valid), 64'd0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (6) step();
      chk("final_count", 64'(o_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
